pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and pipeline-control unit for the 5-stage datapath. Drives the write enables and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. Detects load-use hazards between the instruction in ID and the load held in ID/EX, sequences multi-cycle MDU stalls, and flushes on taken branches. Keeps saturating stall and flush counters for debug.

## Interface
Parameters:
- MDU_LATENCY, 4, EX cycles an MDU op occupies (≥2)
- CNT_W, 16, width of the debug counters

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- id_rs  in  5  source reg 1 of the instruction in ID
- id_rt  in  5  source reg 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  memread_out of ID/EX
- ex_rt  in  5  rt_out of ID/EX (load destination)
- ex_mdu_start  in  1  MDU op present in EX this cycle (first cycle)
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clears to NOP
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads all-zero control fields
- exmem_bubble  out  1  EX/MEM loads all-zero control fields
- mdu_busy  out  1  FSM in MDU_BUSY
- stall_cnt  out  CNT_W  cycles with pc_write=0
- flush_cnt  out  CNT_W  taken-branch flushes

## Operation
- FSM states: RUN, MDU_BUSY. Down-counter mdu_left, width clog2(MDU_LATENCY)+1.
- RUN, priority order:
  - ex_branch_taken=1 → pc_write=1, ifid_flush=1, idex_bubble=1. Load-use is suppressed because the ID instruction is discarded.
  - else ex_mdu_start=1 → next state MDU_BUSY, mdu_left ← MDU_LATENCY-1. This cycle: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
  - else load-use → pc_write=0, ifid_write=0, idex_bubble=1.
  - Load-use condition: ex_memread & (ex_rt≠0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
  - else all enables 1, all bubbles/flush 0.
- MDU_BUSY:
  - pc_write=ifid_write=idex_write=0, exmem_bubble=1.
  - mdu_left decrements each cycle. When mdu_left==1, next state is RUN.
  - ex_branch_taken, ex_mdu_start and load-use inputs are ignored.
  - Total stall = MDU_LATENCY-1 cycles. The MDU result leaves EX on the following RUN cycle.
- stall_cnt +1 every cycle pc_write=0. flush_cnt +1 every cycle ifid_flush=1. Both saturate at all-ones and never wrap.
- idex_write=1 whenever idex_bubble=1.

## Timing
- Control outputs are combinational from inputs plus registered state. They are valid in the same cycle and act at the next clk edge.
- State, mdu_left and counters update on posedge clk.
- Reset (reset_n=0, async, any time, including mid-MDU_BUSY):
  - state ← RUN, mdu_left ← 0, stall_cnt ← 0, flush_cnt ← 0.
  - While reset is held: pc_write=ifid_write=idex_write=1, all bubbles/flush=0, mdu_busy=0.
- Load-use stall lasts exactly 1 cycle. Next cycle the load is in MEM and ID/EX holds a bubble (ex_memread=0).
- Branch and MDU start in the same cycle: branch wins and MDU_BUSY is not entered. The upstream source guarantees this cannot occur legally; the rule is defined for robustness.
- ex_mdu_start held high across the busy period is ignored. Only a RUN-state assertion starts a sequence.

## Structure
- Shared pipeline package: state enum {RUN, MDU_BUSY}, MDU_LATENCY default, and the zero-control constant used by idex_bubble/exmem_bubble in the register blocks.
- One sub-module, sat_counter (CNT_W, inc, clear), instantiated twice for stall_cnt and flush_cnt.
- Hazard compare and FSM stay in the top module.

## Test plan
- ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1; next cycle all enables 1.
- Same stimulus with ex_rt=0, or id_uses_rs=0 → no stall; stall_cnt stays 0.
- ex_mdu_start pulse, MDU_LATENCY=4 → mdu_busy=1 for 3 cycles with exmem_bubble=1 and all enables 0; then RUN; stall_cnt=4 (start cycle + 3).
- ex_branch_taken=1 together with a load-use match → ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
- reset_n=0 asserted two cycles into MDU_BUSY → mdu_busy=0 immediately (asynchronously); counters 0; after release, normal RUN behaviour.
- Force stall_cnt to 0xFFFE, then apply 3 load-use stalls → counter reads 0xFFFF and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM states, default geometry, and the
// all-zero control bundle that bubbles load into the ID/EX and EX/MEM registers.
package pipe_hazard_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_BUSY = 1'b1
   } hz_state_t;

   localparam int unsigned MDU_LATENCY_DEF = 4;
   localparam int unsigned CNT_W_DEF       = 16;

   // Control fields carried down the pipe; a bubble loads CTRL_NOP.
   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       branch;
      logic       alusrc;
      logic [1:0] aluop;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_NOP = '0;

   // Load in EX writes a register that the instruction in ID is about to read.
   function automatic logic load_use_hit(
      input logic       memread,
      input logic [4:0] ld_rt,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rs,
      input logic       uses_rt
   );
      return memread && (ld_rt != 5'd0) &&
             ((uses_rs && (rs == ld_rt)) || (uses_rt && (rt == ld_rt)));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter for pipeline debug statistics.
module sat_counter
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] count
);

   // Count events, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / pipeline-control unit: load-use stalls, multi-cycle MDU stalls,
// taken-branch flushes, plus saturating stall/flush debug counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             ex_mdu_start,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_bubble,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned LW = $clog2(MDU_LATENCY) + 1;

   hz_state_t   state;
   logic [LW-1:0] mdu_left;
   logic        load_use;

   assign load_use = load_use_hit(ex_memread, ex_rt, id_rs, id_rt,
                                  id_uses_rs, id_uses_rt);

   // Hazard FSM: a RUN-state MDU start (not pre-empted by a branch) holds the
   // pipe for MDU_LATENCY-1 further cycles; mdu_busy is registered with state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RUN;
         mdu_left <= '0;
         mdu_busy <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (!ex_branch_taken && ex_mdu_start) begin
                  state    <= MDU_BUSY;
                  mdu_left <= LW'(MDU_LATENCY - 1);
                  mdu_busy <= 1'b1;
               end
            end
            MDU_BUSY: begin
               mdu_left <= mdu_left - LW'(1);
               if (mdu_left == LW'(1)) begin
                  state    <= RUN;
                  mdu_busy <= 1'b0;
               end
            end
            default: begin
               state    <= RUN;
               mdu_busy <= 1'b0;
            end
         endcase
      end
   end

   // Pipeline enables/bubbles from state and current EX/ID contents; while
   // reset is held the pipe free-runs regardless of the hazard inputs.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      if (reset_n) begin
         if (state == MDU_BUSY) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
         end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (ex_mdu_start) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (~pc_write),
      .clear   (1'b0),
      .count   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (ifid_flush),
      .clear   (1'b0),
      .count   (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int L    = 4;
   localparam int CMAX = 65535;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
   logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_memread = 1'b0;
   logic        ex_mdu_start = 1'b0, ex_branch_taken = 1'b0;
   logic        pc_write, ifid_write, ifid_flush, idex_write;
   logic        idex_bubble, exmem_bubble, mdu_busy;
   logic [15:0] stall_cnt, flush_cnt;
   logic [6:0]  ctl;

   int n_cmp = 0;
   int n_err = 0;

   // model: remaining busy cycles and event totals
   int m_busy = 0;
   int m_stall = 0;
   int m_flush = 0;

   // Expected control vectors {pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_bub, busy}
   localparam logic [6:0] V_RUN   = 7'b1101000;
   localparam logic [6:0] V_LU    = 7'b0001100;
   localparam logic [6:0] V_START = 7'b0000010;
   localparam logic [6:0] V_BUSY  = 7'b0000011;
   localparam logic [6:0] V_BR    = 7'b1111100;

   assign ctl = {pc_write, ifid_write, ifid_flush, idex_write,
                 idex_bubble, exmem_bubble, mdu_busy};

   pipe_hazard_ctrl #(.MDU_LATENCY(L), .CNT_W(16)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .ex_memread      (ex_memread),
      .ex_rt           (ex_rt),
      .ex_mdu_start    (ex_mdu_start),
      .ex_branch_taken (ex_branch_taken),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .idex_write      (idex_write),
      .idex_bubble     (idex_bubble),
      .exmem_bubble    (exmem_bubble),
      .mdu_busy        (mdu_busy),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit lu_now();
      return ex_memread && (ex_rt != 0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
   endfunction

   // What the pipe should do this cycle given the model and current inputs.
   function automatic logic [6:0] model_ctl();
      if (m_busy > 0)        return V_BUSY;
      if (ex_branch_taken)   return V_BR;
      if (ex_mdu_start)      return V_START;
      if (lu_now())          return V_LU;
      return V_RUN;
   endfunction

   function automatic int sat_add(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   task automatic set_idle();
      id_rs = '0; id_rt = '0; ex_rt = '0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
      ex_mdu_start = 1'b0; ex_branch_taken = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] r);
      ex_memread = 1'b1; ex_rt = r; id_rs = r; id_uses_rs = 1'b1;
   endtask

   // Advance the model by the current cycle, then move to the next negedge.
   task automatic advance();
      if (m_busy > 0) begin
         m_stall = sat_add(m_stall);
         m_busy  = m_busy - 1;
      end else if (ex_branch_taken) begin
         m_flush = sat_add(m_flush);
      end else if (ex_mdu_start) begin
         m_stall = sat_add(m_stall);
         m_busy  = L - 1;
      end else if (lu_now()) begin
         m_stall = sat_add(m_stall);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      set_idle();
      m_busy = 0; m_stall = 0; m_flush = 0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      set_load_use(5'd7);
      ex_mdu_start = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== V_RUN) begin
         n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, V_RUN);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || mdu_busy !== 1'b0) begin
         n_err++; $display("FAIL reset_state: stall=%0d flush=%0d busy=%b want 0 0 0",
                           stall_cnt, flush_cnt, mdu_busy);
      end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use(5'd5);
      #1;
      n_cmp++;
      if (ctl !== V_LU) begin
         n_err++; $display("FAIL load_use_ctl: got %b want %b", ctl, V_LU);
      end
      advance();
      ex_memread = 1'b0;
      #1;
      n_cmp++;
      if (ctl !== V_RUN || stall_cnt !== 16'd1) begin
         n_err++; $display("FAIL load_use_after: ctl=%b stall=%0d want %b 1", ctl, stall_cnt, V_RUN);
      end
   endtask

   task automatic test_no_stall();
      do_reset();
      set_load_use(5'd0);
      #1;
      n_cmp++;
      if (ctl !== V_RUN) begin
         n_err++; $display("FAIL no_stall_r0: got %b want %b", ctl, V_RUN);
      end
      advance();
      set_load_use(5'd5);
      id_uses_rs = 1'b0;
      id_rt = 5'd5;
      #1;
      n_cmp++;
      if (ctl !== V_RUN) begin
         n_err++; $display("FAIL no_stall_unused: got %b want %b", ctl, V_RUN);
      end
      advance();
      set_idle();
      #1;
      n_cmp++;
      if (stall_cnt !== 16'd0) begin
         n_err++; $display("FAIL no_stall_cnt: got %0d want 0", stall_cnt);
      end
   endtask

   task automatic test_mdu();
      do_reset();
      ex_mdu_start = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== V_START) begin
         n_err++; $display("FAIL mdu_start: got %b want %b", ctl, V_START);
      end
      advance();
      // busy period ignores branch, load-use and a held start
      ex_branch_taken = 1'b1;
      set_load_use(5'd3);
      for (int i = 0; i < L - 1; i++) begin
         #1;
         n_cmp++;
         if (ctl !== V_BUSY) begin
            n_err++; $display("FAIL mdu_busy_%0d: got %b want %b", i, ctl, V_BUSY);
         end
         advance();
      end
      set_idle();
      #1;
      n_cmp++;
      if (ctl !== V_RUN || stall_cnt !== 16'd4 || flush_cnt !== 16'd0) begin
         n_err++; $display("FAIL mdu_done: ctl=%b stall=%0d flush=%0d want %b 4 0",
                           ctl, stall_cnt, flush_cnt, V_RUN);
      end
   endtask

   task automatic test_branch_priority();
      do_reset();
      ex_branch_taken = 1'b1;
      ex_mdu_start = 1'b1;
      set_load_use(5'd9);
      #1;
      n_cmp++;
      if (ctl !== V_BR) begin
         n_err++; $display("FAIL branch_ctl: got %b want %b", ctl, V_BR);
      end
      advance();
      set_idle();
      #1;
      n_cmp++;
      if (ctl !== V_RUN || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
         n_err++; $display("FAIL branch_after: ctl=%b flush=%0d stall=%0d want %b 1 0",
                           ctl, flush_cnt, stall_cnt, V_RUN);
      end
   endtask

   task automatic test_reset_mid_mdu();
      do_reset();
      ex_mdu_start = 1'b1;
      advance();
      ex_mdu_start = 1'b0;
      advance();
      #1;
      n_cmp++;
      if (mdu_busy !== 1'b1) begin
         n_err++; $display("FAIL mid_mdu_busy: got %b want 1", mdu_busy);
      end
      #1;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (ctl !== V_RUN || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
         n_err++; $display("FAIL async_reset: ctl=%b stall=%0d flush=%0d want %b 0 0",
                           ctl, stall_cnt, flush_cnt, V_RUN);
      end
      m_busy = 0; m_stall = 0; m_flush = 0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      set_load_use(5'd12);
      #1;
      n_cmp++;
      if (ctl !== V_LU) begin
         n_err++; $display("FAIL post_reset_lu: got %b want %b", ctl, V_LU);
      end
      advance();
      set_idle();
      #1;
      n_cmp++;
      if (ctl !== V_RUN || stall_cnt !== 16'd1) begin
         n_err++; $display("FAIL post_reset_run: ctl=%b stall=%0d want %b 1", ctl, stall_cnt, V_RUN);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         ex_rt           = 5'($urandom_range(0, 3));
         id_uses_rs      = 1'($urandom_range(0, 1));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_memread      = ($urandom_range(0, 2) != 0);
         ex_mdu_start    = ($urandom_range(0, 7) == 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         #1;
         n_cmp++;
         if (ctl !== model_ctl()) begin
            n_err++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, ctl, model_ctl());
         end
         n_cmp++;
         if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
            n_err++; $display("FAIL rand_cnt[%0d]: stall=%0d flush=%0d want %0d %0d",
                              i, stall_cnt, flush_cnt, m_stall, m_flush);
         end
         advance();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      set_load_use(5'd5);
      repeat (CMAX - 1) @(posedge clk);
      @(negedge clk);
      m_stall = CMAX - 1;
      #1;
      n_cmp++;
      if (stall_cnt !== 16'hFFFE) begin
         n_err++; $display("FAIL sat_pre: got %h want fffe", stall_cnt);
      end
      for (int i = 0; i < 3; i++) advance();
      #1;
      n_cmp++;
      if (stall_cnt !== 16'(m_stall) || stall_cnt !== 16'hFFFF) begin
         n_err++; $display("FAIL sat_hold: got %h want ffff", stall_cnt);
      end
      set_idle();
      advance();
      #1;
      n_cmp++;
      if (stall_cnt !== 16'hFFFF) begin
         n_err++; $display("FAIL sat_idle: got %h want ffff", stall_cnt);
      end
   endtask

   initial begin
      set_idle();
      test_reset();
      test_load_use();
      test_no_stall();
      test_mdu();
      test_branch_priority();
      test_reset_mid_mdu();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
